// File: rtl/matrix_readback_scanner_pkg.sv
// Shared constants, scan state encoding and addressing helpers for the matrix readback path.
package matrix_readback_scanner_pkg;

    localparam int unsigned ELEM_W   = 4;
    localparam int unsigned MAX_DIM  = 8;
    localparam int unsigned MATRIX_W = MAX_DIM * MAX_DIM * ELEM_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StShow = 2'd2,
        StDone = 2'd3
    } scan_state_e;

    // Bit offset of element (row, col); stride is always MAX_DIM to match the entry side.
    function automatic int unsigned elem_offset(input logic [2:0] row, input logic [2:0] col);
        return (MAX_DIM * 32'(row) + 32'(col)) * ELEM_W;
    endfunction

    // {d7..d0}: d5:d4 = 8r+c, d3 = row, d2 = col, d0 = data, others zero.
    function automatic logic [31:0] pack_digits(input logic [2:0] row, input logic [2:0] col,
                                                input logic [3:0] data);
        return {8'h00, 2'b00, row, col, 1'b0, row, 1'b0, col, 4'h0, data};
    endfunction

endpackage

// File: rtl/matrix_readback_scanner_dwell_timer.sv
// Dwell timer for auto-stepping displays: single-cycle tick every DWELL_CYCLES enabled cycles.
module scan_dwell_timer #(
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic board_clk,
    input  logic Reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = $clog2(DWELL_CYCLES);

    logic [CntW-1:0] cnt_q;

    assign tick = en && (cnt_q == CntW'(DWELL_CYCLES - 1));

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (clr || !en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/matrix_readback_scanner.sv
// Snapshots the packed matrix and walks it row-major, presenting each element for the SSD mux.
module matrix_readback_scanner
    import matrix_readback_scanner_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 50000000
) (
    input  logic                board_clk,
    input  logic                Reset,
    input  logic                start,
    input  logic                ack,
    input  logic                step,
    input  logic                auto_en,
    input  logic [3:0]          dim,
    input  logic [MATRIX_W-1:0] matrix_flat,
    output logic [2:0]          cur_row,
    output logic [2:0]          cur_col,
    output logic [3:0]          cur_data,
    output logic                elem_valid,
    output logic                busy,
    output logic                done,
    output logic [31:0]         disp_digits
);

    scan_state_e         state_q;
    logic [MATRIX_W-1:0] shadow_q;
    logic [3:0]          dim_l_q;
    logic [2:0]          row_q, col_q;
    logic [3:0]          data_q;
    logic                valid_q, busy_q, done_q;
    logic [31:0]         disp_q;

    logic [3:0] dim_eff;
    logic       last_elem, row_end;
    logic [2:0] row_nxt, col_nxt;
    logic       timer_en, timer_clr, tick, adv;

    always_comb begin
        dim_eff   = (dim == 4'd0 || dim > 4'd8) ? 4'd8 : dim;
        row_end   = ({1'b0, col_q} == dim_l_q - 4'd1);
        last_elem = row_end && ({1'b0, row_q} == dim_l_q - 4'd1);
        row_nxt   = row_end ? row_q + 3'd1 : row_q;
        col_nxt   = row_end ? 3'd0 : col_q + 3'd1;
        timer_en  = auto_en && (state_q == StShow);
        adv       = (state_q == StShow) && (step || tick);
        timer_clr = adv || (state_q != StShow);
    end

    scan_dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .board_clk(board_clk),
        .Reset    (Reset),
        .en       (timer_en),
        .clr      (timer_clr),
        .tick     (tick)
    );

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            dim_l_q  <= 4'd8;
            row_q    <= '0;
            col_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            disp_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLoad;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    shadow_q <= matrix_flat;
                    dim_l_q  <= dim_eff;
                    row_q    <= '0;
                    col_q    <= '0;
                    data_q   <= matrix_flat[ELEM_W-1:0];
                    disp_q   <= pack_digits(3'd0, 3'd0, matrix_flat[ELEM_W-1:0]);
                    valid_q  <= 1'b1;
                    state_q  <= StShow;
                end
                StShow: begin
                    if (start) begin
                        state_q <= StLoad;
                        valid_q <= 1'b0;
                    end else if (adv) begin
                        if (last_elem) begin
                            state_q <= StDone;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            row_q  <= row_nxt;
                            col_q  <= col_nxt;
                            data_q <= shadow_q[elem_offset(row_nxt, col_nxt) +: ELEM_W];
                            disp_q <= pack_digits(row_nxt, col_nxt,
                                                  shadow_q[elem_offset(row_nxt, col_nxt) +: ELEM_W]);
                        end
                    end
                end
                StDone: begin
                    if (start) begin
                        state_q <= StLoad;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (ack) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                        row_q   <= '0;
                        col_q   <= '0;
                        data_q  <= '0;
                        disp_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cur_row     = row_q;
    assign cur_col     = col_q;
    assign cur_data    = data_q;
    assign elem_valid  = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign disp_digits = disp_q;

endmodule
